vc_req_ctrl: RTL and testbench
==============================

// Module: vc_req_ctrl
// PURPOSE
//  Requester-side partner of the per-output-VC input arbiters in the VC allocator.
//  There is one instance per input VC.
//  It takes the routed head flit and drives reqva toward the arbiters.
//  It accepts one grant among simultaneous vc_grant pulses and confirms that grant with grant_success.
//  It then holds the output VC while it feeds flits to the switch allocator.
//  On tail departure it releases the VC with a one-cycle vc_unlock pulse.
// PARAMETERS
//  NUM_VCS     router_pkg  number of output VCs per output port (>=2)
//  VC_ID_BITS  router_pkg  width of the output VC index
//  IDLE_DIR    L           dir_t value driven on reqva when not requesting; never equal to any arbitrated output
//  WAIT_BITS   8           width of the saturating VA-wait counter
// PORTS
//  clk            in   1           clock
//  arst           in   1           asynchronous reset, active-high
//  head_valid     in   1           head flit at buffer front with route computed
//  head_dir       in   dir_t       output port from route compute (sampled in IDLE)
//  vc_grant       in   NUM_VCS     grants from the NUM_VCS output-VC arbiters of the requested port
//  flit_valid     in   1           buffer non-empty
//  flit_tail      in   1           front flit is a tail (head==tail for 1-flit packets)
//  credit_avail   in   1           downstream credit available for out_vc
//  sa_gnt         in   1           switch allocator grant for this VC
//  reqva          out  dir_t       VA request direction
//  grant_success  out  NUM_VCS     one-hot acceptance, same cycle as vc_grant
//  vc_unlock      out  1           one-cycle release pulse at tail departure
//  out_vc         out  VC_ID_BITS  allocated output VC (valid in ACTIVE)
//  out_dir        out  dir_t       latched output port
//  sa_req         out  1           switch allocation request
//  flit_pop       out  1           dequeue front flit
//  va_wait        out  WAIT_BITS   cycles spent in VA for the current packet, saturating
// BEHAVIOUR
//  Reset values (arst=1, async):
//   state=IDLE, reqva=IDLE_DIR, grant_success=0, vc_unlock=0, sa_req=0, flit_pop=0
//   out_vc=0, out_dir=IDLE_DIR, rr_ptr=0, va_wait=0
//  IDLE:
//   reqva=IDLE_DIR and all other strobes 0.
//   If head_valid: out_dir<=head_dir, va_wait<=0, go to VA.
//  VA:
//   reqva=out_dir, driven from a register.
//   If vc_grant==0: stay in VA; va_wait increments and saturates at all-ones.
//   Else: pick the first set bit of vc_grant starting at rr_ptr, wrapping from NUM_VCS-1 to 0. Call it v.
//   grant_success=onehot(v) combinationally in the same cycle; other bits stay 0.
//   Next cycle: out_vc<=v, rr_ptr<=(v+1) mod NUM_VCS, state=ACTIVE, reqva=IDLE_DIR.
//  ACTIVE:
//   sa_req=flit_valid&credit_avail, combinational.
//   flit_pop=sa_gnt&sa_req.
//   On a pop with flit_tail: vc_unlock=1 in that same cycle, then IDLE next cycle.
//   Pops without tail stay in ACTIVE.
//   sa_gnt while sa_req=0 is ignored (no pop).
//  Latencies:
//   VA grant to first possible sa_req: 1 cycle.
//   Tail pop to next reqva: 2 cycles (IDLE, then VA).
//  Invariants:
//   grant_success is nonzero only in VA.
//   vc_unlock is nonzero only in ACTIVE.
//   grant_success and vc_unlock are never asserted together.
//   At most one grant_success bit is set.
//  Reset mid-packet: returns to IDLE immediately with no vc_unlock pulse.
//   The arbiters are reset by the same reset.
// TESTING
//  T1 single grant:
//   head_valid, head_dir=E; vc_grant=0010 two cycles later
//   -> grant_success=0010 same cycle, out_vc=1, ACTIVE next cycle.
//  T2 simultaneous grants:
//   rr_ptr=2, vc_grant=1011 -> grant_success=1000, out_vc=3, rr_ptr=0.
//   Next packet with vc_grant=1011 -> picks 0.
//  T3 credit stall:
//   ACTIVE, flit_valid=1, credit_avail=0 for 5 cycles -> sa_req=0, no pop.
//   credit_avail=1 with sa_gnt -> flit_pop=1.
//  T4 1-flit packet:
//   head+tail popped in the first ACTIVE cycle -> vc_unlock=1 that cycle, IDLE next.
//   grant_success and vc_unlock are never high together.
//  T5 VA starvation:
//   no grant for 300 cycles with WAIT_BITS=8 -> va_wait=255 and holds.
//   reqva stays E throughout.
//  T6 reset in ACTIVE:
//   arst pulse mid-body -> all outputs at reset values, vc_unlock=0.
//   The new head re-requests normally.

Source files
------------

// File: rtl/vc_req_ctrl.sv
// Per-input-VC requester for VC allocation: requests an output VC for the routed head flit,
// accepts one round-robin-selected grant, feeds the switch allocator and releases on tail.
module vc_req_ctrl #(
  parameter int unsigned          NUM_VCS    = 4,
  parameter int unsigned          VC_ID_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int unsigned          DIR_BITS   = 3,
  parameter logic [DIR_BITS-1:0]  IDLE_DIR   = DIR_BITS'(4),
  parameter int unsigned          WAIT_BITS  = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  head_valid_i,
  input  logic [DIR_BITS-1:0]   head_dir_i,
  input  logic [NUM_VCS-1:0]    vc_grant_i,
  input  logic                  flit_valid_i,
  input  logic                  flit_tail_i,
  input  logic                  credit_avail_i,
  input  logic                  sa_gnt_i,
  output logic [DIR_BITS-1:0]   reqva_o,
  output logic [NUM_VCS-1:0]    grant_success_o,
  output logic                  vc_unlock_o,
  output logic [VC_ID_BITS-1:0] out_vc_o,
  output logic [DIR_BITS-1:0]   out_dir_o,
  output logic                  sa_req_o,
  output logic                  flit_pop_o,
  output logic [WAIT_BITS-1:0]  va_wait_o
);

  typedef enum logic [1:0] {StIdle, StVa, StActive} state_e;

  state_e                state_q, state_d;
  logic [DIR_BITS-1:0]   reqva_q, reqva_d;
  logic [DIR_BITS-1:0]   out_dir_q, out_dir_d;
  logic [VC_ID_BITS-1:0] out_vc_q, out_vc_d;
  logic [VC_ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [WAIT_BITS-1:0]  va_wait_q, va_wait_d;

  logic                  pick_found;
  logic [VC_ID_BITS-1:0] pick_vc;
  logic [VC_ID_BITS-1:0] pick_next;

  // First set grant bit at or after rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_vc    = '0;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_VCS;
      if (!pick_found && vc_grant_i[idx[VC_ID_BITS-1:0]]) begin
        pick_found = 1'b1;
        pick_vc    = VC_ID_BITS'(idx);
      end
    end
    pick_next = (pick_vc == VC_ID_BITS'(NUM_VCS - 1)) ? '0 : pick_vc + VC_ID_BITS'(1);
  end

  always_comb begin
    state_d         = state_q;
    reqva_d         = reqva_q;
    out_dir_d       = out_dir_q;
    out_vc_d        = out_vc_q;
    rr_ptr_d        = rr_ptr_q;
    va_wait_d       = va_wait_q;
    grant_success_o = '0;
    vc_unlock_o     = 1'b0;
    sa_req_o        = 1'b0;
    flit_pop_o      = 1'b0;

    case (state_q)
      StIdle: begin
        if (head_valid_i) begin
          out_dir_d = head_dir_i;
          reqva_d   = head_dir_i;
          va_wait_d = '0;
          state_d   = StVa;
        end
      end
      StVa: begin
        if (pick_found) begin
          grant_success_o[pick_vc] = 1'b1;
          out_vc_d = pick_vc;
          rr_ptr_d = pick_next;
          reqva_d  = IDLE_DIR;
          state_d  = StActive;
        end else if (va_wait_q != '1) begin
          va_wait_d = va_wait_q + WAIT_BITS'(1);
        end
      end
      StActive: begin
        sa_req_o   = flit_valid_i & credit_avail_i;
        flit_pop_o = sa_gnt_i & sa_req_o;
        if (flit_pop_o && flit_tail_i) begin
          vc_unlock_o = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        reqva_d = IDLE_DIR;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= StIdle;
      reqva_q   <= IDLE_DIR;
      out_dir_q <= IDLE_DIR;
      out_vc_q  <= '0;
      rr_ptr_q  <= '0;
      va_wait_q <= '0;
    end else begin
      state_q   <= state_d;
      reqva_q   <= reqva_d;
      out_dir_q <= out_dir_d;
      out_vc_q  <= out_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      va_wait_q <= va_wait_d;
    end
  end

  assign reqva_o   = reqva_q;
  assign out_dir_o = out_dir_q;
  assign out_vc_o  = out_vc_q;
  assign va_wait_o = va_wait_q;

endmodule

// File: tb/tb_vc_req_ctrl.sv
// Bench for vc_req_ctrl: directed scenarios plus random traffic, each cycle compared against a
// packet-level reference model (requesting / holding a VC) derived from the allocation rules.
module tb_vc_req_ctrl;

  localparam int unsigned NV = 4;
  localparam int unsigned VB = 2;
  localparam int unsigned DB = 3;
  localparam int unsigned WB = 8;
  localparam logic [DB-1:0] DIR_N = 3'd0;
  localparam logic [DB-1:0] DIR_E = 3'd1;
  localparam logic [DB-1:0] DIR_W = 3'd3;
  localparam logic [DB-1:0] DIR_L = 3'd4;

  logic          clk = 1'b0;
  logic          arst;
  logic          head_valid;
  logic [DB-1:0] head_dir;
  logic [NV-1:0] vc_grant;
  logic          flit_valid, flit_tail, credit_avail, sa_gnt;
  logic [DB-1:0] reqva, out_dir;
  logic [NV-1:0] grant_success;
  logic          vc_unlock, sa_req, flit_pop;
  logic [VB-1:0] out_vc;
  logic [WB-1:0] va_wait;

  vc_req_ctrl #(
    .NUM_VCS   (NV),
    .VC_ID_BITS(VB),
    .DIR_BITS  (DB),
    .IDLE_DIR  (DIR_L),
    .WAIT_BITS (WB)
  ) dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .head_valid_i   (head_valid),
    .head_dir_i     (head_dir),
    .vc_grant_i     (vc_grant),
    .flit_valid_i   (flit_valid),
    .flit_tail_i    (flit_tail),
    .credit_avail_i (credit_avail),
    .sa_gnt_i       (sa_gnt),
    .reqva_o        (reqva),
    .grant_success_o(grant_success),
    .vc_unlock_o    (vc_unlock),
    .out_vc_o       (out_vc),
    .out_dir_o      (out_dir),
    .sa_req_o       (sa_req),
    .flit_pop_o     (flit_pop),
    .va_wait_o      (va_wait)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: packet-level view.
  bit m_req, m_hold;
  int m_dir, m_vc, m_ptr, m_wait;

  // Outputs observed at the last checked negedge.
  logic [NV-1:0] obs_gs;
  logic          obs_unlock, obs_pop, obs_sa_req;
  logic [DB-1:0] obs_reqva;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic mdl_reset();
    m_req = 0; m_hold = 0; m_dir = DIR_L; m_vc = 0; m_ptr = 0; m_wait = 0;
  endtask

  task automatic idle_inputs();
    head_valid = 0; head_dir = DIR_N; vc_grant = '0;
    flit_valid = 0; flit_tail = 0; credit_avail = 0; sa_gnt = 0;
  endtask

  // One clock: at negedge compare DUT to model for current inputs, then advance the model.
  task automatic cycle();
    int e_reqva, e_gs, e_sareq, e_pop, e_unlock, v;
    @(negedge clk);
    e_reqva = DIR_L; e_gs = 0; e_sareq = 0; e_pop = 0; e_unlock = 0; v = -1;
    if (m_req) begin
      e_reqva = m_dir;
      for (int i = 0; i < NV; i++)
        if (v < 0 && vc_grant[(m_ptr + i) % NV]) v = (m_ptr + i) % NV;
      if (v >= 0) e_gs = 1 << v;
    end else if (m_hold) begin
      e_sareq  = int'(flit_valid && credit_avail);
      e_pop    = int'(e_sareq != 0 && sa_gnt);
      e_unlock = int'(e_pop != 0 && flit_tail);
    end
    check_eq("reqva", 32'(reqva), e_reqva);
    check_eq("grant_success", 32'(grant_success), e_gs);
    check_eq("sa_req", 32'(sa_req), e_sareq);
    check_eq("flit_pop", 32'(flit_pop), e_pop);
    check_eq("vc_unlock", 32'(vc_unlock), e_unlock);
    check_eq("out_dir", 32'(out_dir), m_dir);
    check_eq("out_vc", 32'(out_vc), m_vc);
    check_eq("va_wait", 32'(va_wait), m_wait);
    check_eq("inv_gs_unlock", 32'((|grant_success) && vc_unlock), 0);
    obs_gs = grant_success; obs_unlock = vc_unlock; obs_pop = flit_pop;
    obs_sa_req = sa_req; obs_reqva = reqva;
    // Advance model.
    if (m_req) begin
      if (v >= 0) begin
        m_req = 0; m_hold = 1; m_vc = v; m_ptr = (v + 1) % NV;
      end else if (m_wait < 255) begin
        m_wait++;
      end
    end else if (m_hold) begin
      if (e_unlock != 0) m_hold = 0;
    end else if (head_valid) begin
      m_req = 1; m_dir = head_dir; m_wait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Drive a head into IDLE and wait `gap` VA cycles without grant.
  task automatic start_pkt(input logic [DB-1:0] dir, input int gap);
    idle_inputs();
    head_valid = 1; head_dir = dir;
    cycle();
    idle_inputs();
    for (int i = 0; i < gap; i++) cycle();
  endtask

  task automatic grant_cycle(input logic [NV-1:0] g);
    vc_grant = g;
    cycle();
    vc_grant = '0;
  endtask

  task automatic pop_tail();
    idle_inputs();
    flit_valid = 1; credit_avail = 1; sa_gnt = 1; flit_tail = 1;
    cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mdl_reset();
    arst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_reqva", 32'(reqva), DIR_L);
    check_eq("rst_out_dir", 32'(out_dir), DIR_L);
    check_eq("rst_out_vc", 32'(out_vc), 0);
    check_eq("rst_va_wait", 32'(va_wait), 0);
    check_eq("rst_gs", 32'(grant_success), 0);
    arst = 0;
    cycle();

    // T1 single grant two cycles after head.
    start_pkt(DIR_E, 1);
    grant_cycle(4'b0010);
    check_eq("t1_gs", 32'(obs_gs), 32'h2);
    check_eq("t1_out_vc", 32'(out_vc), 1);
    cycle();
    check_eq("t1_reqva_active", 32'(obs_reqva), DIR_L);
    pop_tail();

    // T2 simultaneous grants with rr_ptr=2, then rr_ptr=0.
    start_pkt(DIR_E, 0);
    grant_cycle(4'b1011);
    check_eq("t2_gs_a", 32'(obs_gs), 32'h8);
    check_eq("t2_out_vc_a", 32'(out_vc), 3);
    pop_tail();
    start_pkt(DIR_N, 0);
    grant_cycle(4'b1011);
    check_eq("t2_gs_b", 32'(obs_gs), 32'h1);
    pop_tail();

    // T3 credit stall then pop.
    start_pkt(DIR_W, 0);
    grant_cycle(4'b0100);
    flit_valid = 1; credit_avail = 0; sa_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("t3_stall_pop", 32'(obs_pop), 0);
    end
    credit_avail = 1;
    cycle();
    check_eq("t3_pop", 32'(obs_pop), 1);
    // sa_gnt without sa_req is ignored.
    credit_avail = 0; flit_tail = 1;
    cycle();
    check_eq("t3_no_req_pop", 32'(obs_pop), 0);
    pop_tail();

    // T4 one-flit packet popped in first ACTIVE cycle.
    start_pkt(DIR_E, 0);
    grant_cycle(4'b0001);
    pop_tail();
    check_eq("t4_unlock", 32'(obs_unlock), 1);
    check_eq("t4_gs_clear", 32'(obs_gs), 0);
    cycle();
    check_eq("t4_idle_reqva", 32'(obs_reqva), DIR_L);

    // T5 VA starvation: saturating wait counter, reqva holds E.
    start_pkt(DIR_E, 300);
    check_eq("t5_va_wait", 32'(va_wait), 255);
    check_eq("t5_reqva", 32'(reqva), DIR_E);
    grant_cycle(4'b1111);
    check_eq("t5_wait_hold", 32'(va_wait), 255);
    pop_tail();

    // T6 asynchronous reset mid-packet.
    start_pkt(DIR_N, 0);
    grant_cycle(4'b1000);
    flit_valid = 1; credit_avail = 1; sa_gnt = 1; flit_tail = 0;
    cycle();
    #3 arst = 1;
    #1;
    check_eq("t6_unlock", 32'(vc_unlock), 0);
    check_eq("t6_sa_req", 32'(sa_req), 0);
    check_eq("t6_pop", 32'(flit_pop), 0);
    check_eq("t6_out_vc", 32'(out_vc), 0);
    check_eq("t6_out_dir", 32'(out_dir), DIR_L);
    check_eq("t6_reqva", 32'(reqva), DIR_L);
    mdl_reset();
    idle_inputs();
    @(posedge clk); #1;
    arst = 0;
    start_pkt(DIR_W, 0);
    grant_cycle(4'b0110);
    check_eq("t6_regrant", 32'(obs_gs), 32'h2);
    pop_tail();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      head_valid   = 1'($urandom_range(0, 1));
      head_dir     = DB'($urandom_range(0, 3));
      vc_grant     = ($urandom_range(0, 2) == 0) ? NV'($urandom) : '0;
      flit_valid   = 1'($urandom_range(0, 3) != 0);
      credit_avail = 1'($urandom_range(0, 3) != 0);
      sa_gnt       = 1'($urandom_range(0, 1));
      flit_tail    = 1'($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
